// File: rtl/add_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : add_share_ctrl
// Brief    : Round-robin sharing of one adder among NUM_REQ requesters with a
//            tagged valid/ready response channel.
// Options  : ADD_SHARE_OVF_EN adds rsp_ovf (signed overflow of the sum).
// Revision : 1.0 - initial release
// ============================================================================
module add_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_result,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready,
`ifdef ADD_SHARE_OVF_EN
    output logic                     rsp_ovf,
`endif
    output logic                     busy
);

    localparam logic [1:0]      c_ST_IDLE = 2'd0;
    localparam logic [1:0]      c_ST_EXEC = 2'd1;
    localparam logic [1:0]      c_ST_RESP = 2'd2;
    localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] w_winner;
    logic            w_found;
    logic            w_grant;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        logic [ID_W-1:0] v_idx;
        v_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_grant     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    w_grant             = 1'b1;
                    w_state_nxt         = c_ST_EXEC;
                end
            end
            c_ST_EXEC: w_state_nxt = c_ST_RESP;
            c_ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign busy = (r_state != c_ST_IDLE);

    // Operands stay put between grants so the shared adder output is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= c_PTR_RST;
            r_id      <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifdef ADD_SHARE_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            if (w_grant) begin
                add_a    <= req_a[w_winner*WIDTH +: WIDTH];
                add_b    <= req_b[w_winner*WIDTH +: WIDTH];
                r_id     <= w_winner;
                r_rr_ptr <= w_winner;
            end
            if (r_state == c_ST_EXEC) begin
                rsp_data  <= add_result;
                rsp_id    <= r_id;
                rsp_valid <= 1'b1;
`ifdef ADD_SHARE_OVF_EN
                rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                             (add_result[WIDTH-1] != add_a[WIDTH-1]);
`endif
            end else if ((r_state == c_ST_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_share_ctrl
// Brief    : Self-checking bench for add_share_ctrl (vector table plus
//            cycle model with response scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_result;
    logic                     rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_ready = 1'b1;
    logic                     busy;
`ifdef ADD_SHARE_OVF_EN
    logic                     rsp_ovf;
`endif

    always #5 clk = ~clk;

    assign add_result = add_a + add_b;

    add_share_ctrl #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
`ifdef ADD_SHARE_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_ovf;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        logic             ovf;
    } exp_t;

    exp_t             sb_q[$];
    logic [ID_W-1:0]  log_id[$];
    logic [WIDTH-1:0] log_data[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Cycle model: predicts grants/state and scoreboards responses.
    int               m_state = 0;
    int               m_ptr   = NUM_REQ - 1;
    int               m_w;
    logic [NUM_REQ-1:0] m_er;
    logic [WIDTH-1:0] m_a, m_b, m_s;
    exp_t             m_e;

    always @(negedge clk) begin
        if (rst) begin
            m_state = 0;
            m_ptr   = NUM_REQ - 1;
            sb_q.delete();
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_rsp_data", 64'(rsp_data), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("rst_add_a", 64'(add_a), 64'd0);
        end else begin
            m_er = '0;
            m_w  = -1;
            if (m_state == 0) begin
                m_w = rr_pick(req_valid, m_ptr);
                if (m_w >= 0) m_er[m_w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(m_er));
            chk("busy", 64'(busy), 64'(m_state != 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_state == 2));
            if (m_state == 2 && sb_q.size() > 0) begin
                chk("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
                chk("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
`ifdef ADD_SHARE_OVF_EN
                chk("rsp_ovf_sb", 64'(rsp_ovf), 64'(sb_q[0].ovf));
`endif
            end
            case (m_state)
                0: if (m_w >= 0) begin
                    m_a     = req_a[m_w*WIDTH +: WIDTH];
                    m_b     = req_b[m_w*WIDTH +: WIDTH];
                    m_s     = m_a + m_b;
                    m_e.id  = ID_W'(m_w);
                    m_e.data = m_s;
                    m_e.ovf = (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_s[WIDTH-1] != m_a[WIDTH-1]);
                    sb_q.push_back(m_e);
                    m_ptr   = m_w;
                    m_state = 1;
                end
                1: m_state = 2;
                default: if (rsp_ready) begin
                    log_id.push_back(rsp_id);
                    log_data.push_back(rsp_data);
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    m_state = 0;
                end
            endcase
        end
    end

    task automatic wait_grant(input int r);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_wait", 64'(req_ready[r]), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             vecs[5];
        int               n;
        logic [ID_W-1:0]  exp_ids[5];
        logic [WIDTH-1:0] exp_dat[5];

        vecs[0] = '{32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[2] = '{32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b1};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1};
        vecs[4] = '{32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  1'b0};
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd100};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd0);

        // Single requester 0 through the vector table.
        for (int i = 0; i < 5; i++) begin
            req_a[0 +: WIDTH] = vecs[i].a;
            req_b[0 +: WIDTH] = vecs[i].b;
            req_valid = 4'b0001;
            wait_grant(0);
            req_valid = '0;
            wait_rsp(n);
            chk("rsp_latency", 64'(n), 64'd1);
            chk("vec_sum", 64'(rsp_data), 64'(vecs[i].exp_sum));
            chk("vec_id", 64'(rsp_id), 64'd0);
`ifdef ADD_SHARE_OVF_EN
            chk("vec_ovf", 64'(rsp_ovf), 64'(vecs[i].exp_ovf));
`endif
            @(posedge clk);
            #1;
        end

        // Reset during EXEC discards the operation and restores priority.
        req_a[0 +: WIDTH] = 32'd3;
        req_b[0 +: WIDTH] = 32'd4;
        req_valid = 4'b0001;
        wait_grant(0);
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_add_a", 64'(add_a), 64'd0);
        chk("async_add_b", 64'(add_b), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        req_a[0 +: WIDTH] = 32'd10;
        req_b[0 +: WIDTH] = 32'd20;
        req_a[WIDTH +: WIDTH] = 32'd30;
        req_b[WIDTH +: WIDTH] = 32'd40;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 4'b0010;
        wait_grant(1);
        req_valid = '0;
        wait_rsp(n);
        chk("post_rst_r1_sum", 64'(rsp_data), 64'd70);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // All requesters valid: strict rotation.
        log_id.delete();
        log_data.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = WIDTH'(i);
            req_b[i*WIDTH +: WIDTH] = 32'd100;
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(k % NUM_REQ);
            if (k == 4) req_valid = '0;
        end
        wait_rsp(n);
        @(posedge clk);
        #1;
        chk("rot_count", 64'(log_id.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < log_id.size()) begin
                chk("rot_id", 64'(log_id[k]), 64'(exp_ids[k]));
                chk("rot_data", 64'(log_data[k]), 64'(exp_dat[k]));
            end
        end

        // Backpressure in RESP while requester 2 waits.
        req_a[WIDTH +: WIDTH] = 32'd50;
        req_b[WIDTH +: WIDTH] = 32'd60;
        req_valid = 4'b0010;
        wait_grant(1);
        req_a[2*WIDTH +: WIDTH] = 32'd7;
        req_b[2*WIDTH +: WIDTH] = 32'd8;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_data", 64'(rsp_data), 64'd110);
            chk("hold_id", 64'(rsp_id), 64'd1);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("accept_cycle_no_grant", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("grant_after_accept", 64'(req_ready), 64'b0100);

        // Requester 1 requests only while busy, then withdraws.
        @(posedge clk);
        #1 req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_a[3*WIDTH +: WIDTH] = 32'hDEAD_0000;
        req_b[3*WIDTH +: WIDTH] = 32'h0000_BEEF;
        req_a[0 +: WIDTH] = 32'd1;
        req_b[0 +: WIDTH] = 32'd2;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("rr_after_withdraw", 64'(req_ready), 64'b1000);
        @(posedge clk);
        #1 req_valid = 4'b0001;
        wait_grant(0);
        req_valid = '0;
        wait_rsp(n);
        chk("last_sum", 64'(rsp_data), 64'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_share_ctrl.md
Name: add_share_ctrl

Overview:
- Round-robin scheduler that shares one 32-bit ADD datapath instance among NUM_REQ requesters, e.g. PC+4, branch-target and address-generation users.
- Grants one request at a time and drives the shared adder's operand inputs from registered operands.
- Captures the adder result and returns it, tagged with the requester ID, over a valid/ready response channel that supports backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width; must match the ADD instance.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NUM_REQ  one-hot grant; zero when not in IDLE.
- add_a  out  WIDTH  to shared ADD A_add.
- add_b  out  WIDTH  to shared ADD B_add.
- add_result  in  WIDTH  from shared ADD result_A; treated as combinational.
- rsp_valid  out  1  result available.
- rsp_data  out  WIDTH  registered sum.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first), rsp_valid=0, rsp_data=0, rsp_id=0, add_a=0, add_b=0, busy=0. req_ready is 0 out of reset when no requests are pending.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr+1 upward modulo NUM_REQ.
  - req_ready[winner]=1 combinationally; all other ready bits are 0.
  - On handshake: latch req_a/req_b of the winner into add_a/add_b, latch winner into id_q, set rr_ptr=winner, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC: the shared adder settles on the registered add_a/add_b. At the clock edge, rsp_data <= add_result, rsp_id <= id_q, rsp_valid <= 1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On accept: rsp_valid <= 0, go to IDLE.
  - No new grant is issued in RESP, even in the accept cycle.
- Timing: grant handshake in cycle T; rsp_valid high from T+2; minimum issue interval is 3 cycles.
- Arithmetic: modulo 2^WIDTH; carry-out is discarded.
- Requester rules:
  - A requester must hold req_valid and operands stable until it sees req_ready.
  - Dropping req_valid before grant withdraws the request with no side effects.
  - req_valid changes outside IDLE are ignored.
- Operand hold: add_a/add_b retain the last granted operands in IDLE and RESP; they change only on a grant.
- All requesters valid: grants rotate 0,1,2,3,0,...
- Single requester: granted on every IDLE visit.
- rsp_ready high while rsp_valid is low: no effect.
- Reset asserted mid-operation, in any state: the in-flight operation is discarded, no response is produced, and all registers return to reset values immediately.

Optional Feature:
- Macro: ADD_SHARE_OVF_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), signed two's-complement overflow of the captured operation.
  - rsp_ovf = (add_a[WIDTH-1]==add_b[WIDTH-1]) && (add_result[WIDTH-1]!=add_a[WIDTH-1]), registered in EXEC alongside rsp_data.
  - Held with rsp_data in RESP; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0001, a=5, b=7:
  - req_ready=4'b0001 in the same cycle.
  - rsp_valid 2 cycles later with rsp_data=12, rsp_id=0; busy high for those cycles.
- All four requesters valid, rsp_ready tied 1, operands a=i, b=100:
  - Grants in order 0,1,2,3,0.
  - rsp_data 100,101,102,103,100; one response every 3 cycles.
- a=32'hFFFF_FFFF, b=1:
  - rsp_data=0.
  - With ADD_SHARE_OVF_EN, rsp_ovf=0. With a=32'h7FFF_FFFF, b=1, rsp_ovf=1.
- Hold rsp_ready=0 for 5 cycles in RESP while requester 2 is valid:
  - rsp_* stable and req_ready=0 throughout.
  - After accept, requester 2 is granted on the next cycle in IDLE.
- Assert rst during EXEC of a=3, b=4:
  - rsp_valid stays 0, state returns to IDLE, outputs read reset values asynchronously.
  - The next request after reset is served normally with requester 0 priority.
- Requester 1 raises req_valid then drops it before grant (state not IDLE):
  - No response with rsp_id=1 is ever produced; rr_ptr is unchanged.
